// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - core-to-memory request/response bus
//
// Purpose: carries the core's multicycle memory request interface into
// mem_ctrl. The core holds mem_read or mem_write high until it sees the
// one-cycle mem_resp pulse.
//
// Signals:
//   mem_addr   core byte address
//   mem_wdata  core write data
//   mem_read   read request, held until mem_resp
//   mem_write  write request, held until mem_resp
//   mem_rdata  registered read data from the controller
//   mem_resp   transaction complete, one-cycle pulse
//
// Modports: master = core side, slave = controller side.

interface mem_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_rdata,
        input  mem_resp
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_rdata,
        output mem_resp
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - core request to single-port synchronous SRAM controller
//
// Purpose: accepts one core request at a time, strobes the SRAM for one
// cycle, waits READ_LATENCY cycles for read data, and answers with a
// one-cycle mem_resp. Misaligned, out-of-range and read+write requests are
// recorded in a sticky error register.
//
// Parameters:
//   ADDR_WIDTH    SRAM word-address width (2^ADDR_WIDTH 32-bit words)
//   READ_LATENCY  cycles from the SRAM strobe edge to valid sram_rdata (1..4)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   core          core request bus (mem_ctrl_if.slave)
//   sram_cs       SRAM chip select, one-cycle strobe
//   sram_we       SRAM write enable, qualified by sram_cs
//   sram_addr     SRAM word address
//   sram_wdata    SRAM write data
//   sram_rdata    SRAM read data
//   err           sticky error flag
//   err_addr      byte address of the first erroring access
//   err_clr       clears err and err_addr

module mem_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_ctrl_if.slave             core,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  err,
    output logic [31:0]           err_addr,
    input  logic                  err_clr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // Counter is loaded in ACCESS and reaches 0 in the capture cycle.
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  lat_cnt;
    logic        req_write;
    logic [31:0] rdata_q;
    logic        resp_q;

    logic        req;
    logic        accept;
    logic        out_of_range;
    logic        misaligned;
    logic        both_kinds;
    logic        new_err;

    assign req          = core.mem_read | core.mem_write;
    assign accept       = (state == IDLE) && req;
    assign out_of_range = (core.mem_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign misaligned   = core.mem_addr[1:0] != 2'b00;
    assign both_kinds   = core.mem_read & core.mem_write;
    assign new_err      = accept && (out_of_range || misaligned || both_kinds);

    assign core.mem_rdata = rdata_q;
    assign core.mem_resp  = resp_q;

    // Request is only sampled in IDLE, so a request the core still holds
    // during RESP is not taken again; the first IDLE cycle may accept the
    // next one. sram_addr/sram_wdata double as the latched request and hold
    // their value outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= 2'd0;
            req_write  <= 1'b0;
            rdata_q    <= 32'd0;
            resp_q     <= 1'b0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        req_write <= core.mem_write;
                        if (out_of_range) begin
                            // No SRAM access; reads return zero.
                            state  <= RESP;
                            resp_q <= 1'b1;
                            if (!core.mem_write) begin
                                rdata_q <= 32'd0;
                            end
                        end else begin
                            state      <= ACCESS;
                            sram_cs    <= 1'b1;
                            sram_we    <= core.mem_write;
                            sram_addr  <= core.mem_addr[ADDR_WIDTH+1:2];
                            sram_wdata <= core.mem_wdata;
                        end
                    end
                end
                ACCESS: begin
                    sram_cs <= 1'b0;
                    sram_we <= 1'b0;
                    if (req_write) begin
                        state  <= RESP;
                        resp_q <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rdata_q <= sram_rdata;
                        state   <= RESP;
                        resp_q  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    resp_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Only the first error after a clear is recorded. A clear arriving with
    // a new error lets the error win and record the new address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_addr <= 32'd0;
        end else if (new_err) begin
            err <= 1'b1;
            if (!err || err_clr) begin
                err_addr <= core.mem_addr;
            end
        end else if (err_clr) begin
            err      <= 1'b0;
            err_addr <= 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl at read latency 1 and 3

module tb_mem_ctrl;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: READ_LATENCY=1, index 1: READ_LATENCY=3
    logic [1:0]        c_rd, c_wr, c_clr;
    logic [1:0][31:0]  c_addr, c_wd;

    logic        cs0, cs1, we0, we1, err0, err1;
    logic [11:0] sa0, sa1;
    logic [31:0] swd0, swd1, srd0, srd1, ea0, ea1;

    logic [1:0]       o_resp, o_cs, o_we, o_err;
    logic [1:0][31:0] o_rdata, o_swd, o_eaddr;
    logic [1:0][11:0] o_saddr;

    mem_ctrl_if bus0 ();
    mem_ctrl_if bus1 ();

    assign bus0.mem_addr  = c_addr[0];
    assign bus0.mem_wdata = c_wd[0];
    assign bus0.mem_read  = c_rd[0];
    assign bus0.mem_write = c_wr[0];
    assign bus1.mem_addr  = c_addr[1];
    assign bus1.mem_wdata = c_wd[1];
    assign bus1.mem_read  = c_rd[1];
    assign bus1.mem_write = c_wr[1];

    assign o_resp  = {bus1.mem_resp, bus0.mem_resp};
    assign o_rdata = {bus1.mem_rdata, bus0.mem_rdata};
    assign o_cs    = {cs1, cs0};
    assign o_we    = {we1, we0};
    assign o_err   = {err1, err0};
    assign o_saddr = {sa1, sa0};
    assign o_swd   = {swd1, swd0};
    assign o_eaddr = {ea1, ea0};

    mem_ctrl #(.ADDR_WIDTH(12), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .core(bus0),
        .sram_cs(cs0), .sram_we(we0), .sram_addr(sa0), .sram_wdata(swd0),
        .sram_rdata(srd0), .err(err0), .err_addr(ea0), .err_clr(c_clr[0])
    );

    mem_ctrl #(.ADDR_WIDTH(12), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .core(bus1),
        .sram_cs(cs1), .sram_we(we1), .sram_addr(sa1), .sram_wdata(swd1),
        .sram_rdata(srd1), .err(err1), .err_addr(ea1), .err_clr(c_clr[1])
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // SRAM models: synchronous write, read data valid READ_LATENCY edges
    // after the strobe edge, garbage otherwise.
    logic [31:0] smem [2][4096];
    logic [31:0] pipe [2][3];
    assign srd0 = pipe[0][0];
    assign srd1 = pipe[1][2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4096; i++) smem[d][i] <= init_word(i);
            for (int j = 0; j < 3; j++) pipe[d][j] <= 32'hDEAD_BEEF;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (o_cs[d] && o_we[d]) smem[d][o_saddr[d]] <= o_swd[d];
                pipe[d][0] <= (o_cs[d] && !o_we[d]) ? smem[d][o_saddr[d]] : 32'hDEAD_BEEF;
                pipe[d][1] <= pipe[d][0];
                pipe[d][2] <= pipe[d][1];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem [2][4096];
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];
    logic [31:0] exp_eaddr [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int d);
        check("rst_rdata", o_rdata[d], 32'd0);
        check("rst_resp", 32'(o_resp[d]), 32'd0);
        check("rst_cs", 32'(o_cs[d]), 32'd0);
        check("rst_we", 32'(o_we[d]), 32'd0);
        check("rst_saddr", 32'(o_saddr[d]), 32'd0);
        check("rst_swdata", o_swd[d], 32'd0);
        check("rst_err", 32'(o_err[d]), 32'd0);
        check("rst_eaddr", o_eaddr[d], 32'd0);
    endtask

    task automatic do_txn(input int d, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd, input bit clr);
        bit          oor, mis, newerr;
        int          word, lat_exp, cs_n, cs_k, resp_k;
        oor     = addr >= 32'(4 * 4096);
        mis     = (addr % 4) != 0;
        newerr  = oor || mis || (rd && wr);
        word    = int'((addr / 4) % 4096);
        lat_exp = oor ? 1 : (wr ? 2 : 2 + lat_of(d));

        @(negedge clk);
        c_addr[d] = addr;
        c_wd[d]   = wd;
        c_rd[d]   = rd;
        c_wr[d]   = wr;
        c_clr[d]  = clr;

        if (newerr) begin
            if (!exp_err[d] || clr) exp_eaddr[d] = addr;
            exp_err[d] = 1'b1;
        end else if (clr) begin
            exp_err[d]   = 1'b0;
            exp_eaddr[d] = 32'd0;
        end

        cs_n = 0; cs_k = -1; resp_k = -1;
        for (int k = 1; k <= 16 && resp_k < 0; k++) begin
            @(negedge clk);
            c_clr[d] = 1'b0;
            if (o_cs[d]) begin
                cs_n++;
                cs_k = k;
                check("strobe_we", 32'(o_we[d]), 32'(wr));
                check("strobe_addr", 32'(o_saddr[d]), 32'(word));
                if (wr) check("strobe_wdata", o_swd[d], wd);
            end
            if (o_resp[d]) resp_k = k;
        end

        if (!oor && wr) exp_mem[d][word] = wd;
        if (!wr) exp_rdata[d] = oor ? 32'd0 : exp_mem[d][word];

        check("resp_latency", 32'(resp_k), 32'(lat_exp));
        check("strobe_count", 32'(cs_n), oor ? 32'd0 : 32'd1);
        if (!oor) check("strobe_cycle", 32'(cs_k), 32'd1);
        check("rdata", o_rdata[d], exp_rdata[d]);
        check("err", 32'(o_err[d]), 32'(exp_err[d]));
        check("err_addr", o_eaddr[d], exp_eaddr[d]);

        // The core drops its request right after the edge that ends RESP.
        if (resp_k > 0) begin
            @(posedge clk);
            #1;
        end
        c_rd[d] = 1'b0;
        c_wr[d] = 1'b0;
    endtask

    task automatic clr_err(input int d);
        @(negedge clk);
        c_clr[d] = 1'b1;
        @(negedge clk);
        c_clr[d] = 1'b0;
        exp_err[d]   = 1'b0;
        exp_eaddr[d] = 32'd0;
        check("clr_err", 32'(o_err[d]), 32'd0);
        check("clr_eaddr", o_eaddr[d], 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d, cat;
        bit          rd, wr, clr;
        logic [31:0] addr;

        rst_n = 1'b0;
        c_rd = '0; c_wr = '0; c_clr = '0; c_addr = '0; c_wd = '0;
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 4096; i++) exp_mem[dd][i] = init_word(i);
            exp_rdata[dd] = 32'd0;
            exp_err[dd]   = 1'b0;
            exp_eaddr[dd] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;

        // basic write/read on both latencies
        do_txn(0, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("read_cafe", o_rdata[0], 32'hCAFE_F00D);
        repeat (3) @(negedge clk);
        check("rdata_held", o_rdata[0], 32'hCAFE_F00D);
        do_txn(1, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
        do_txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("read_cafe_l3", o_rdata[1], 32'hCAFE_F00D);

        // back-to-back read then write
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        do_txn(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0);
        check("rdata_after_write", o_rdata[0], 32'hCAFE_F00D);

        // out-of-range read and clear
        do_txn(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 1'b0);
        check("oor_eaddr", o_eaddr[0], 32'h0001_0000);
        clr_err(0);

        // misaligned write, then out-of-range keeps first address
        do_txn(0, 1'b0, 1'b1, 32'h13, 32'h1234_5678, 1'b0);
        check("mis_eaddr", o_eaddr[0], 32'h13);
        do_txn(0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("sticky_eaddr", o_eaddr[0], 32'h13);
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // clear together with a new error, and read+write together
        do_txn(0, 1'b1, 1'b0, 32'h21, 32'h0, 1'b1);
        do_txn(0, 1'b1, 1'b1, 32'h30, 32'h7777_0000, 1'b0);
        clr_err(0);
        clr_err(1);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            d    = int'($urandom_range(0, 1));
            cat  = int'($urandom_range(0, 9));
            addr = 32'($urandom_range(0, 31)) * 32'd4;
            wr   = $urandom_range(0, 1) == 1;
            rd   = !wr;
            clr  = $urandom_range(0, 7) == 0;
            if (cat == 7) addr = addr | 32'($urandom_range(1, 3));
            if (cat == 8) addr = 32'($urandom_range(32'h4000, 32'hFFFF_FFFF));
            if (cat == 9) begin rd = 1'b1; wr = 1'b1; end
            do_txn(d, rd, wr, addr, $urandom, clr);
        end

        // reset during WAIT of the latency-3 controller
        do_txn(1, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0);
        @(negedge clk);
        c_addr[1] = 32'h10;
        c_rd[1]   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        c_rd[1] = 1'b0;
        for (int dd = 0; dd < 2; dd++) begin
            exp_rdata[dd] = 32'd0;
            exp_err[dd]   = 1'b0;
            exp_eaddr[dd] = 32'd0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("resp_in_reset", 32'(o_resp), 32'd0);
        end
        rst_n = 1'b1;
        do_txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("idle_resp", 32'(o_resp), 32'd0);
            check("idle_cs", 32'(o_cs), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side stage directly downstream of the core: consumes the core's multicycle mem_read/mem_write/mem_resp request interface and drives a single-port synchronous word SRAM.
- Latches each request, drives the SRAM strobe for one cycle, and waits a parameterised read latency.
- Returns registered read data with a one-cycle mem_resp pulse.
- Flags misaligned and out-of-range accesses in a sticky error register.

Parameters:
ADDR_WIDTH, 12, SRAM word-address width (SRAM holds 2^ADDR_WIDTH 32-bit words).
READ_LATENCY, 1, cycles from the SRAM strobe edge to valid sram_rdata; legal range 1..4.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
mem_addr  input  32  core byte address
mem_wdata  input  32  core write data
mem_read  input  1  core read request, held high until mem_resp
mem_write  input  1  core write request, held high until mem_resp
mem_rdata  output  32  registered read data
mem_resp  output  1  transaction complete, one-cycle pulse
sram_cs  output  1  SRAM chip select, one-cycle strobe
sram_we  output  1  SRAM write enable, qualified by sram_cs
sram_addr  output  ADDR_WIDTH  SRAM word address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data
err  output  1  sticky error flag
err_addr  output  32  byte address of first erroring access
err_clr  input  1  clears err and err_addr

Behaviour:
- Clock and reset: single clock, clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE; mem_rdata=0, mem_resp=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0, err=0, err_addr=0; latency counter 0.
- Reset asserted mid-transaction aborts it with no mem_resp; any SRAM write already strobed stands.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: on a cycle with mem_read|mem_write, latch mem_addr, mem_wdata and kind at the clock edge.
  - Kind is write if mem_write=1, so write wins when both are asserted; both asserted also sets err.
  - In-range request: go to ACCESS.
  - Out-of-range request (mem_addr[31:ADDR_WIDTH+2] != 0): go straight to RESP with no SRAM access; a read returns mem_rdata=0; sets err.
- Misaligned address (mem_addr[1:0] != 0): sets err, but the access still proceeds using word address mem_addr[ADDR_WIDTH+1:2].
- ACCESS: sram_cs=1; sram_we=1 for a write; sram_addr and sram_wdata from the latched request. Lasts exactly one cycle.
  - Write: next state RESP.
  - Read: next state WAIT with counter=READ_LATENCY-1.
- WAIT: decrement the counter each cycle. In the cycle it reads 0, capture sram_rdata into mem_rdata at the edge and go to RESP.
  - For READ_LATENCY=1 the capture is the first WAIT cycle.
- RESP: mem_resp=1 for exactly one cycle, then IDLE.
  - The core's request is still asserted during RESP; the controller must not re-sample it there.
  - A new request seen in the first IDLE cycle after RESP is accepted, giving back-to-back transactions.
- Latency from request cycle N:
  - write: ACCESS at N+1, RESP at N+2.
  - read: ACCESS at N+1, RESP at N+2+READ_LATENCY.
  - out-of-range: RESP at N+1.
- mem_rdata holds its value until the next read capture or an out-of-range read; writes do not change it.
- Request deasserted before mem_resp: the transaction still completes and mem_resp still pulses.
- sram_addr and sram_wdata hold their last values outside ACCESS; sram_cs and sram_we are 0 outside ACCESS.
- Error register:
  - err_addr loads only when err transitions 0->1; later errors are not recorded until cleared.
  - err_clr clears err and err_addr at the edge.
  - err_clr together with a new error in the same cycle: error wins, so err=1 and err_addr takes the new address.

Test Plan:
- Reset, then write 0xCAFEF00D to 0x10 -> sram_cs=sram_we=1 with sram_addr=4 in cycle N+1; mem_resp pulses in N+2; err=0.
- Read 0x10 with READ_LATENCY=1 and SRAM model returning 0xCAFEF00D -> mem_resp at N+3, mem_rdata=0xCAFEF00D held afterwards; repeat with READ_LATENCY=3 -> mem_resp at N+5.
- Back-to-back: read, and the core raises a write in the cycle after mem_resp -> write ACCESS two cycles later; exactly one mem_resp per transaction.
- Read of 0x0001_0000 (out of range, ADDR_WIDTH=12) -> no sram_cs, mem_resp at N+1, mem_rdata=0, err=1, err_addr=0x0001_0000; err_clr -> err=0, err_addr=0.
- Write to 0x13 (misaligned) -> SRAM write at word 4, err=1, err_addr=0x13; a later out-of-range access leaves err_addr=0x13.
- rst_n asserted during WAIT -> outputs at reset values immediately, no mem_resp; a following read completes normally.
